// File: rtl/float_addmul_seq.sv
// float_addmul_seq: multicycle floating-point add/sub/mul unit with valid/ready handshakes and fixed latency.
// Build option: define FLOAT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module float_addmul_seq #(
  parameter int NE = 8,
  parameter int NM = 23
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [1:0]       op_code_i,
  input  logic [NE+NM:0]   op_a_i,
  input  logic [NE+NM:0]   op_b_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [NE+NM:0]   res_o,
  output logic [2:0]       flags_o,
  output logic             busy_o
);
  localparam int W  = NE + NM + 1;
  localparam int MW = NM + 4;
  localparam int EW = NE + 8;
  localparam int PW = 2 * NM + 2;
  localparam int SW = 2 * NM + 4;
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (NE - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << NE) - 2);
  localparam logic signed [EW-1:0] EONE = EW'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, EXEC, NORM, ROUND, DONE} state_t;

  state_t                 state_q;
  logic [1:0]             op_q;
  logic [W-1:0]           a_q, b_q, bypRes_q, res_q;
  logic [2:0]             bypFlags_q, flags_q;
  logic                   byp_q, sub_q, sign_q, zero_q;
  logic signed [EW-1:0]   exp_q;
  logic [MW-1:0]          opX_q, opY_q, mag_q;
  logic                   opReady_q, resValid_q, busy_q;

  logic                   sA, sB, aZero, bZero, aBig;
  logic [NE-1:0]          eA, eB, eBig, eSml, diff;
  logic [NM-1:0]          mA, mB, mBig, mSml;
  logic [SW-1:0]          wide;
  logic                   byp_d, sub_d, sign_d;
  logic [W-1:0]           bypRes_d, res_d;
  logic [2:0]             bypFlags_d, flags_d;
  logic signed [EW-1:0]   expAl_d, expNm_d, expR;
  logic [MW-1:0]          opX_d, opY_d, magEx_d, magNm_d;
  logic [PW-1:0]          prod;
  logic [NM-1:0]          mantR;
  int                     lead, shift;
`ifdef FLOAT_ROUND_NEAREST_EN
  logic                   carry;
`endif

  // Operand unpack, zero/reserved bypass, and alignment of the smaller add/sub operand.
  always_comb begin
    sA = a_q[W-1];
    eA = a_q[W-2:NM];
    mA = a_q[NM-1:0];
    sB = b_q[W-1] ^ (op_q == 2'b01);
    eB = b_q[W-2:NM];
    mB = b_q[NM-1:0];
    aZero = (eA == '0);
    bZero = (eB == '0);
    aBig = (a_q[W-2:0] >= b_q[W-2:0]);
    eBig = aBig ? eA : eB;
    eSml = aBig ? eB : eA;
    mBig = aBig ? mA : mB;
    mSml = aBig ? mB : mA;
    diff = eBig - eSml;
    wide = {1'b1, mSml, 1'b0, {(NM+2){1'b0}}} >> diff;
    byp_d = 1'b0;
    bypRes_d = '0;
    bypFlags_d = '0;
    sub_d = sA ^ sB;
    sign_d = aBig ? sA : sB;
    expAl_d = {{(EW-NE){1'b0}}, eBig};
    opX_d = {2'b01, mBig, 2'b00};
    opY_d = (int'(diff) > NM + 2) ? {{(MW-1){1'b0}}, 1'b1}
                                  : {1'b0, wide[SW-1:NM+2], |wide[NM+1:0]};
    case (op_q)
      2'b10: begin
        sign_d = a_q[W-1] ^ b_q[W-1];
        expAl_d = {{(EW-NE){1'b0}}, eA} + {{(EW-NE){1'b0}}, eB} - BIAS;
        opX_d = {3'b000, 1'b1, mA};
        opY_d = {3'b000, 1'b1, mB};
        if (aZero || bZero) begin
          byp_d = 1'b1;
          bypFlags_d = 3'b001;
        end
      end
      2'b11: begin
        byp_d = 1'b1;
        bypRes_d = a_q;
      end
      default: begin
        if (bZero) begin
          byp_d = 1'b1;
          bypRes_d = a_q;
          bypFlags_d = {2'b00, aZero};
        end else if (aZero) begin
          byp_d = 1'b1;
          bypRes_d = {sB, b_q[W-2:0]};
        end
      end
    endcase
  end

  // Product is reduced to the same carry/hidden/mantissa/guard/sticky layout as the adder.
  always_comb begin
    prod = PW'(opX_q[NM:0]) * PW'(opY_q[NM:0]);
    if (op_q == 2'b10)
      magEx_d = {prod[PW-1:NM-1], |prod[NM-2:0]};
    else
      magEx_d = sub_q ? (opX_q - opY_q) : (opX_q + opY_q);
  end

  always_comb begin
    lead = 0;
    for (int i = 0; i < MW - 1; i++)
      if (mag_q[i]) lead = i;
    shift = (MW - 2) - lead;
    if (mag_q[MW-1]) begin
      magNm_d = {1'b0, mag_q[MW-1:2], mag_q[1] | mag_q[0]};
      expNm_d = exp_q + EONE;
    end else begin
      magNm_d = mag_q << shift;
      expNm_d = exp_q - EW'(shift);
    end
  end

  // Rounding, then saturation on overflow and signed zero on underflow.
  always_comb begin
    mantR = mag_q[MW-3:2];
    expR = exp_q;
`ifdef FLOAT_ROUND_NEAREST_EN
    carry = 1'b0;
    if (mag_q[1] & (mag_q[0] | mag_q[2])) begin
      {carry, mantR} = {1'b0, mag_q[MW-3:2]} + {{NM{1'b0}}, 1'b1};
      if (carry) expR = exp_q + EONE;
    end
`endif
    if (byp_q) begin
      res_d = bypRes_q;
      flags_d = bypFlags_q;
    end else if (zero_q) begin
      res_d = '0;
      flags_d = 3'b001;
    end else if (expR > EMAX) begin
      res_d = {sign_q, EMAX[NE-1:0], {NM{1'b1}}};
      flags_d = 3'b100;
    end else if (expR < EONE) begin
      res_d = {sign_q, {(W-1){1'b0}}};
      flags_d = 3'b011;
    end else begin
      res_d = {sign_q, expR[NE-1:0], mantR};
      flags_d = 3'b000;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      opReady_q <= 1'b1;
      resValid_q <= 1'b0;
      busy_q <= 1'b0;
      res_q <= '0;
      flags_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (op_valid_i) begin
          op_q <= op_code_i;
          a_q <= op_a_i;
          b_q <= op_b_i;
          opReady_q <= 1'b0;
          busy_q <= 1'b1;
          state_q <= ALIGN;
        end
        ALIGN: begin
          byp_q <= byp_d;
          bypRes_q <= bypRes_d;
          bypFlags_q <= bypFlags_d;
          sub_q <= sub_d;
          sign_q <= sign_d;
          exp_q <= expAl_d;
          opX_q <= opX_d;
          opY_q <= opY_d;
          state_q <= EXEC;
        end
        EXEC: begin
          mag_q <= magEx_d;
          state_q <= NORM;
        end
        NORM: begin
          mag_q <= magNm_d;
          exp_q <= expNm_d;
          zero_q <= (mag_q == '0);
          state_q <= ROUND;
        end
        ROUND: begin
          res_q <= res_d;
          flags_q <= flags_d;
          state_q <= DONE;
        end
        DONE: if (!resValid_q) begin
          resValid_q <= 1'b1;
        end else if (res_ready_i) begin
          resValid_q <= 1'b0;
          opReady_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign op_ready_o  = opReady_q;
  assign res_valid_o = resValid_q;
  assign res_o       = res_q;
  assign flags_o     = flags_q;
  assign busy_o      = busy_q;
endmodule

// File: tb/tb_float_addmul_seq.sv
// tb_float_addmul_seq: directed-vector bench for float_addmul_seq at NE=8, NM=23.
// Expected results are hand-computed single-precision encodings.
module tb_float_addmul_seq;
  localparam int NE = 8;
  localparam int NM = 23;
  localparam int W  = NE + NM + 1;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic         opValid = 1'b0;
  logic         resReady = 1'b1;
  logic [1:0]   opCode = 2'b00;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic         opReady, resValid, busy;
  logic [W-1:0] resO;
  logic [2:0]   flagsO;
  int           checks = 0;
  int           errors = 0;

  float_addmul_seq #(.NE(NE), .NM(NM)) dut (
    .clk_i(clk), .rst_n_i(rstN), .op_valid_i(opValid), .op_ready_o(opReady),
    .op_code_i(opCode), .op_a_i(opA), .op_b_i(opB), .res_valid_o(resValid),
    .res_ready_i(resReady), .res_o(resO), .flags_o(flagsO), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Issues one operation, scrambles the inputs after acceptance, waits for res_valid_o.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] code,
                       output logic [W-1:0] res, output logic [2:0] flg, output int lat);
    @(negedge clk);
    opA = a; opB = b; opCode = code; opValid = 1'b1;
    @(posedge clk); #1;
    opValid = 1'b0; opA = 32'hDEADBEEF; opB = 32'h12345678; opCode = 2'b11;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (resValid === 1'b1) begin
        lat = c;
        break;
      end
    end
    res = resO;
    flg = flagsO;
  endtask

  task automatic consume;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (opReady !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0 || resO !== '0 || flagsO !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset: ready=%b valid=%b busy=%b res=%h flags=%b, expected 1 0 0 00000000 000",
               opReady, resValid, busy, resO, flagsO);
    end
    @(negedge clk); rstN = 1'b1;
  endtask

  task automatic test_add;
    logic [W-1:0] va [5] = '{32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h7F7FFFFF, 32'h40000000};
    logic [W-1:0] vb [5] = '{32'h40000000, 32'h3FC00000, 32'h3F000000, 32'h7F7FFFFF, 32'h00000000};
    logic [W-1:0] ve [5] = '{32'h40400000, 32'h40400000, 32'hBF000000, 32'h7F7FFFFF, 32'h40000000};
    logic [2:0]   vf [5] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000};
    logic [W-1:0] res; logic [2:0] flg; int lat;
    for (int i = 0; i < 5; i++) begin
      runOp(va[i], vb[i], 2'b00, res, flg, lat);
      checks++;
      if (res !== ve[i] || flg !== vf[i] || lat != 5) begin
        errors++;
        $display("[TB] FAIL add[%0d]: res=%h flags=%b latency=%0d, expected %h %b 5", i, res, flg, lat, ve[i], vf[i]);
      end
      consume();
    end
  endtask

  task automatic test_sub;
    logic [W-1:0] va [5] = '{32'h3F800000, 32'h40400000, 32'h00000000, 32'h3F800000, 32'h00C00000};
    logic [W-1:0] vb [5] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h00800000};
    logic [W-1:0] ve [5] = '{32'h00000000, 32'h40000000, 32'hC0000000, 32'hBF800000, 32'h00000000};
    logic [2:0]   vf [5] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b011};
    logic [W-1:0] res; logic [2:0] flg; int lat;
    for (int i = 0; i < 5; i++) begin
      runOp(va[i], vb[i], 2'b01, res, flg, lat);
      checks++;
      if (res !== ve[i] || flg !== vf[i] || lat != 5) begin
        errors++;
        $display("[TB] FAIL sub[%0d]: res=%h flags=%b latency=%0d, expected %h %b 5", i, res, flg, lat, ve[i], vf[i]);
      end
      consume();
    end
  endtask

  task automatic test_mul;
    logic [W-1:0] va [7] = '{32'h3FC00000, 32'h7F000000, 32'h00800000, 32'hC0000000,
                             32'h7F800000, 32'h40000000, 32'h3FC00000};
    logic [W-1:0] vb [7] = '{32'h40000000, 32'h7F000000, 32'h00800000, 32'h3FC00000,
                             32'h3F000000, 32'h00000000, 32'h3FC00000};
    logic [W-1:0] ve [7] = '{32'h40400000, 32'h7F7FFFFF, 32'h00000000, 32'hC0400000,
                             32'h7F000000, 32'h00000000, 32'h40100000};
    logic [2:0]   vf [7] = '{3'b000, 3'b100, 3'b011, 3'b000, 3'b000, 3'b001, 3'b000};
    logic [W-1:0] res; logic [2:0] flg; int lat;
    for (int i = 0; i < 7; i++) begin
      runOp(va[i], vb[i], 2'b10, res, flg, lat);
      checks++;
      if (res !== ve[i] || flg !== vf[i] || lat != 5) begin
        errors++;
        $display("[TB] FAIL mul[%0d]: res=%h flags=%b latency=%0d, expected %h %b 5", i, res, flg, lat, ve[i], vf[i]);
      end
      consume();
    end
  endtask

  task automatic test_rounding;
    logic [W-1:0] res; logic [2:0] flg; int lat; logic [W-1:0] exp;
`ifdef FLOAT_ROUND_NEAREST_EN
    exp = 32'h3F800001;
`else
    exp = 32'h3F800000;
`endif
    runOp(32'h3F800000, 32'h33C00000, 2'b00, res, flg, lat);
    checks++;
    if (res !== exp || flg !== 3'b000 || lat != 5) begin
      errors++;
      $display("[TB] FAIL rounding: res=%h flags=%b latency=%0d, expected %h 000 5", res, flg, lat, exp);
    end
    consume();
  endtask

  task automatic test_reserved;
    logic [W-1:0] res; logic [2:0] flg; int lat;
    runOp(32'h12345678, 32'h9ABCDEF0, 2'b11, res, flg, lat);
    checks++;
    if (res !== 32'h12345678 || flg !== 3'b000 || lat != 5) begin
      errors++;
      $display("[TB] FAIL reserved: res=%h flags=%b latency=%0d, expected 12345678 000 5", res, flg, lat);
    end
    consume();
  endtask

  // Holds the result under back-pressure while a new request waits, then checks it starts only after release.
  task automatic test_back_to_back;
    logic [W-1:0] res; logic [2:0] flg; int lat;
    resReady = 1'b0;
    runOp(32'h3F800000, 32'h40000000, 2'b00, res, flg, lat);
    checks++;
    if (res !== 32'h40400000 || flg !== 3'b000 || lat != 5) begin
      errors++;
      $display("[TB] FAIL stall_first: res=%h flags=%b latency=%0d, expected 40400000 000 5", res, flg, lat);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      opValid = 1'b1; opA = 32'h40000000; opB = 32'h40000000; opCode = 2'b10;
      @(posedge clk); #1;
      checks++;
      if (resO !== 32'h40400000 || flagsO !== 3'b000 || resValid !== 1'b1 || opReady !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_hold[%0d]: res=%h flags=%b valid=%b ready=%b, expected 40400000 000 1 0",
                 c, resO, flagsO, resValid, opReady);
      end
    end
    @(negedge clk); resReady = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (opReady !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release: ready=%b valid=%b busy=%b, expected 1 0 0", opReady, resValid, busy);
    end
    @(posedge clk); #1;
    opValid = 1'b0; opCode = 2'b11;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (resValid === 1'b1) begin
        lat = c;
        break;
      end
    end
    checks++;
    if (resO !== 32'h40800000 || flagsO !== 3'b000 || lat != 5) begin
      errors++;
      $display("[TB] FAIL reaccept: res=%h flags=%b latency=%0d, expected 40800000 000 5", resO, flagsO, lat);
    end
    consume();
  endtask

  task automatic test_reset_midop;
    logic seen;
    logic [W-1:0] res; logic [2:0] flg; int lat;
    @(negedge clk);
    opValid = 1'b1; opA = 32'h3FC00000; opB = 32'h40000000; opCode = 2'b10;
    @(posedge clk); #1;
    opValid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || opReady !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_busy: busy=%b ready=%b, expected 1 0", busy, opReady);
    end
    @(negedge clk); rstN = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (opReady !== 1'b1 || resValid !== 1'b0 || busy !== 1'b0 || resO !== '0 || flagsO !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midop_reset: ready=%b valid=%b busy=%b res=%h flags=%b, expected 1 0 0 00000000 000",
               opReady, resValid, busy, resO, flagsO);
    end
    @(negedge clk); rstN = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (resValid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midop_ghost: aborted operation produced activity=%b, expected 0", seen);
    end
    runOp(32'h3F800000, 32'h40000000, 2'b00, res, flg, lat);
    checks++;
    if (res !== 32'h40400000 || flg !== 3'b000 || lat != 5) begin
      errors++;
      $display("[TB] FAIL after_reset: res=%h flags=%b latency=%0d, expected 40400000 000 5", res, flg, lat);
    end
    consume();
  endtask

  initial begin
    $display("[TB] starting float_addmul_seq directed tests");
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_rounding();
    test_reserved();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
